// File: rtl/cpu_consts.sv
// Shared core constants: memory access sizes, LSU state encoding and
// small helpers used by the load/store unit.
package cpu_consts;

  // Decoded access width carried on the data_byte control field.
  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } mem_access_size_t;

  // Load/store unit bus-transaction state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // True when the access cannot be issued as a single aligned word access.
  // DOUBLE_WORD never fits on a 32-bit bus, so it always faults.
  function automatic logic access_faults(input mem_access_size_t size,
                                         input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (size)
      BYTE:        fault = 1'b0;
      HALF_WORD:   fault = addr_lo[0];
      WORD:        fault = (addr_lo != 2'b00);
      DOUBLE_WORD: fault = 1'b1;
      default:     fault = 1'b1;
    endcase
    return fault;
  endfunction

  // Byte-lane enables for an aligned access within the addressed word.
  function automatic logic [3:0] byte_enables(input mem_access_size_t size,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'h0;
    case (size)
      BYTE:      be = 4'b0001 << addr_lo;
      HALF_WORD: be = 4'b0011 << addr_lo;
      WORD:      be = 4'hF;
      default:   be = 4'h0;
    endcase
    return be;
  endfunction

  // Replicate the store value across every lane so the byte enables alone
  // pick the destination bytes; the memory never has to shift data.
  function automatic logic [31:0] replicate_store(input mem_access_size_t size,
                                                  input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = wdata;
    case (size)
      BYTE:      lanes = {4{wdata[7:0]}};
      HALF_WORD: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_data_formatter.sv
// Extracts the addressed byte/halfword from a bus read word and
// sign- or zero-extends it to the register width.
module load_data_formatter
  import cpu_consts::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [1:0]       offset,
  input  mem_access_size_t size,
  input  logic             zero_extnd,
  output logic [XLEN-1:0]  result
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        byte_sign;
  logic        half_sign;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte  = lane[offset];
  assign sel_half  = offset[1] ? rdata[31:16] : rdata[15:0];
  assign byte_sign = ~zero_extnd & sel_byte[7];
  assign half_sign = ~zero_extnd & sel_half[15];

  // Choose the field by access size and extend it to XLEN.
  always_comb begin
    result = '0;
    case (size)
      BYTE:      result = {{(XLEN-8){byte_sign}}, sel_byte};
      HALF_WORD: result = {{(XLEN-16){half_sign}}, sel_half};
      WORD:      result = rdata;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one word-aligned req/gnt/rvalid bus
// transaction per request and returns formatted load data.
module load_store_unit
  import cpu_consts::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  mem_access_size_t req_size_i,
  input  logic             req_zero_extnd_i,
  input  logic [XLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_wdata_i,
  output logic             rsp_valid_o,
  output logic [XLEN-1:0]  rsp_rdata_o,
  output logic             rsp_fault_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_rvalid_i
);

  lsu_state_t       state_reg;
  logic [1:0]       offset_reg;
  mem_access_size_t size_reg;
  logic             zero_extnd_reg;
  logic             accept;
  logic             req_fault;
  logic [XLEN-1:0]  load_result;

  // Ready is the only combinational output; reset blocks new accepts.
  assign req_ready_o = (state_reg == IDLE) & ~reset;
  assign accept      = req_valid_i & req_ready_o;
  assign req_fault   = access_faults(req_size_i, req_addr_i[1:0]);

  // Formatting uses the offset/size/extend latched at accept time.
  load_data_formatter #(.XLEN(XLEN)) u_formatter (
    .rdata      (mem_rdata_i),
    .offset     (offset_reg),
    .size       (size_reg),
    .zero_extnd (zero_extnd_reg),
    .result     (load_result)
  );

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      offset_reg     <= 2'b00;
      size_reg       <= BYTE;
      zero_extnd_reg <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_fault_o    <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      mem_we_o       <= 1'b0;
      mem_be_o       <= 4'h0;
      mem_wdata_o    <= '0;
    end else begin
      // Response is a single-cycle pulse unless re-armed below.
      rsp_valid_o <= 1'b0;
      rsp_fault_o <= 1'b0;
      rsp_rdata_o <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (req_fault) begin
              // Misaligned/illegal: answer immediately, no bus cycle.
              rsp_valid_o <= 1'b1;
              rsp_fault_o <= 1'b1;
            end else begin
              offset_reg     <= req_addr_i[1:0];
              size_reg       <= req_size_i;
              zero_extnd_reg <= req_zero_extnd_i;
              mem_req_o      <= 1'b1;
              mem_addr_o     <= {req_addr_i[XLEN-1:2], 2'b00};
              mem_we_o       <= req_wr_i;
              mem_be_o       <= byte_enables(req_size_i, req_addr_i[1:0]);
              mem_wdata_o    <= replicate_store(req_size_i, req_wdata_i);
              state_reg      <= REQ;
            end
          end
        end
        REQ: begin
          // Bus fields stay frozen until the grant is seen.
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= mem_we_o ? '0 : load_result;
            state_reg   <= IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit and the standalone load formatter.
module tb_load_store_unit;
  import cpu_consts::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_wr_i;
  mem_access_size_t req_size_i;
  logic             req_zero_extnd_i;
  logic [31:0]      req_addr_i;
  logic [31:0]      req_wdata_i;
  logic             rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_fault_o;
  logic             mem_req_o;
  logic             mem_gnt_i;
  logic [31:0]      mem_addr_o;
  logic             mem_we_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;
  logic             mem_rvalid_i;

  logic [31:0]      f_rdata;
  logic [1:0]       f_offset;
  mem_access_size_t f_size;
  logic             f_zx;
  logic [31:0]      f_result;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_wr_i         (req_wr_i),
    .req_size_i       (req_size_i),
    .req_zero_extnd_i (req_zero_extnd_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_fault_o      (rsp_fault_o),
    .mem_req_o        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rvalid_i     (mem_rvalid_i)
  );

  load_data_formatter #(.XLEN(32)) u_fmt (
    .rdata      (f_rdata),
    .offset     (f_offset),
    .size       (f_size),
    .zero_extnd (f_zx),
    .result     (f_result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete bus access with programmable grant/rvalid delays.
  task automatic access(input logic wr, input mem_access_size_t sz, input logic zx,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input int gnt_wait, input int rv_wait, input string tag);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    chk({tag, " ready_at_accept"}, {31'd0, req_ready_o}, 32'd1);
    req_wr_i = wr; req_size_i = sz; req_zero_extnd_i = zx;
    req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
    step();
    // Scramble live inputs so only latched values can produce the result.
    req_valid_i = 1'b0; req_addr_i = ~addr; req_size_i = WORD;
    req_zero_extnd_i = ~zx; req_wdata_i = ~wdata; req_wr_i = ~wr;
    chk({tag, " mem_req"},   {31'd0, mem_req_o}, 32'd1);
    chk({tag, " mem_addr"},  mem_addr_o, exp_addr);
    chk({tag, " mem_we"},    {31'd0, mem_we_o}, {31'd0, wr});
    chk({tag, " mem_be"},    {28'd0, mem_be_o}, {28'd0, exp_be});
    chk({tag, " mem_wdata"}, mem_wdata_o, exp_wdata);
    chk({tag, " ready_busy"}, {31'd0, req_ready_o}, 32'd0);
    for (int i = 0; i < gnt_wait; i++) begin
      step();
      chk({tag, " req_held"},   {31'd0, mem_req_o}, 32'd1);
      chk({tag, " addr_held"},  mem_addr_o, exp_addr);
      chk({tag, " be_held"},    {28'd0, mem_be_o}, {28'd0, exp_be});
      chk({tag, " wdata_held"}, mem_wdata_o, exp_wdata);
      chk({tag, " ready_req"},  {31'd0, req_ready_o}, 32'd0);
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk({tag, " req_dropped"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, " no_early_rsp"}, {31'd0, rsp_valid_o}, 32'd0);
    for (int i = 0; i < rv_wait; i++) begin
      step();
      chk({tag, " wait_no_rsp"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({tag, " ready_wait"},  {31'd0, req_ready_o}, 32'd0);
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A5A5A;
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, " rsp_fault"}, {31'd0, rsp_fault_o}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata_o, exp_rdata);
    chk({tag, " ready_rsp"}, {31'd0, req_ready_o}, 32'd1);
    $display("txn %s addr=%h rdata=%h", tag, addr, rsp_rdata_o);
  endtask

  // Faulting request; settle=0 leaves the bench in the fault response cycle.
  task automatic fault_case(input logic wr, input mem_access_size_t sz,
                            input logic [31:0] addr, input bit settle, input string tag);
    chk({tag, " ready"}, {31'd0, req_ready_o}, 32'd1);
    req_wr_i = wr; req_size_i = sz; req_zero_extnd_i = 1'b0;
    req_addr_i = addr; req_wdata_i = 32'h11223344; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, " rsp_fault"}, {31'd0, rsp_fault_o}, 32'd1);
    chk({tag, " rsp_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, " no_mem_req"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, " ready_after"}, {31'd0, req_ready_o}, 32'd1);
    $display("txn %s addr=%h fault=%0b", tag, addr, rsp_fault_o);
    if (settle) begin
      step();
      chk({tag, " pulse_end"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({tag, " still_no_req"}, {31'd0, mem_req_o}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid_i = 1'b0; req_wr_i = 1'b0; req_size_i = BYTE;
    req_zero_extnd_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rdata_i = '0; mem_rvalid_i = 1'b0;
    f_rdata = '0; f_offset = 2'd0; f_size = BYTE; f_zx = 1'b0;

    // Standalone formatter vectors.
    f_rdata = 32'h80112233; f_offset = 2'd1; f_size = BYTE; f_zx = 1'b0; #1;
    chk("fmt lb_off1", f_result, 32'h00000022);
    f_offset = 2'd3; #1;
    chk("fmt lb_off3", f_result, 32'hFFFFFF80);
    f_zx = 1'b1; #1;
    chk("fmt lbu_off3", f_result, 32'h00000080);
    f_size = HALF_WORD; f_offset = 2'd2; f_zx = 1'b0; #1;
    chk("fmt lh_off2", f_result, 32'hFFFF8011);
    f_offset = 2'd0; #1;
    chk("fmt lh_off0", f_result, 32'h00002233);
    f_size = WORD; f_zx = 1'b1; #1;
    chk("fmt lw", f_result, 32'h80112233);

    // Reset state.
    step(); step();
    chk("rst ready",     {31'd0, req_ready_o}, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst rsp_fault", {31'd0, rsp_fault_o}, 32'd0);
    chk("rst rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst mem_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst mem_addr",  mem_addr_o, 32'd0);
    chk("rst mem_we",    {31'd0, mem_we_o}, 32'd0);
    chk("rst mem_be",    {28'd0, mem_be_o}, 32'd0);
    chk("rst mem_wdata", mem_wdata_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst ready", {31'd0, req_ready_o}, 32'd1);
    step();

    // Loads and stores, minimum latency.
    access(1'b0, WORD,      1'b0, 32'h00001000, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, "LW");
    access(1'b0, BYTE,      1'b0, 32'h00001003, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 0, "LB");
    access(1'b0, BYTE,      1'b1, 32'h00001003, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'h00000080, 0, 0, "LBU");
    access(1'b0, HALF_WORD, 1'b0, 32'h00001002, 32'h0, 32'h80112233, 4'b1100, 32'h0, 32'hFFFF8011, 0, 0, "LH");
    access(1'b0, HALF_WORD, 1'b1, 32'h00002000, 32'h0, 32'h1234F00D, 4'b0011, 32'h0, 32'h0000F00D, 0, 0, "LHU");
    access(1'b1, BYTE,      1'b0, 32'h00002001, 32'h000000AB, 32'h12345678, 4'b0010, 32'hABABABAB, 32'h0, 0, 0, "SB");
    access(1'b1, HALF_WORD, 1'b0, 32'h00002002, 32'h1234CAFE, 32'h87654321, 4'b1100, 32'hCAFECAFE, 32'h0, 0, 0, "SH");

    // Stalled grant and delayed rvalid, then a back-to-back store.
    access(1'b0, WORD, 1'b0, 32'h00003004, 32'h0, 32'hCAFEBABE, 4'hF, 32'h0, 32'hCAFEBABE, 4, 3, "LW_stall");
    access(1'b1, WORD, 1'b0, 32'h00003008, 32'h01020304, 32'hFFFFFFFF, 4'hF, 32'h01020304, 32'h0, 0, 0, "SW_b2b");
    step();

    // Faults; the last one is followed by an accept in its response cycle.
    fault_case(1'b0, WORD,        32'h00001002, 1'b1, "F_LW");
    fault_case(1'b1, HALF_WORD,   32'h00001001, 1'b1, "F_SH");
    fault_case(1'b0, DOUBLE_WORD, 32'h00001000, 1'b0, "F_DW");
    access(1'b0, BYTE, 1'b0, 32'h00001001, 32'h0, 32'h80112233, 4'b0010, 32'h0, 32'h00000022, 0, 0, "LB_after_fault");
    step();

    // Reset while in REQ drops the bus request.
    req_wr_i = 1'b0; req_size_i = WORD; req_addr_i = 32'h00004000; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk("rstreq mem_req_before", {31'd0, mem_req_o}, 32'd1);
    reset = 1'b1;
    step();
    chk("rstreq mem_req_dropped", {31'd0, mem_req_o}, 32'd0);
    chk("rstreq ready_in_reset", {31'd0, req_ready_o}, 32'd0);
    reset = 1'b0;
    step();

    // Reset while in WAIT, then a stray rvalid must not respond.
    req_addr_i = 32'h00004004; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("rstwait in_wait", {31'd0, mem_req_o}, 32'd0);
    reset = 1'b1;
    step();
    chk("rstwait ready_in_reset", {31'd0, req_ready_o}, 32'd0);
    chk("rstwait no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    reset = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    step();
    mem_rvalid_i = 1'b0;
    step();
    chk("rstwait stray_ignored", {31'd0, rsp_valid_o}, 32'd0);
    chk("rstwait idle_ready", {31'd0, req_ready_o}, 32'd1);
    access(1'b0, WORD, 1'b0, 32'h00005000, 32'h0, 32'h13579BDF, 4'hF, 32'h0, 32'h13579BDF, 1, 1, "LW_after_reset");
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core. Takes load/store requests from execute, driven by the decoded `data_req`, `data_wr`, `data_byte` and `zero_extnd` control fields. Performs a single word-aligned data-bus transaction using a req/gnt/rvalid handshake, and returns load data to the register-file write-back mux (`MEM` source). Supports one outstanding transaction and stalls the pipeline through `req_ready_o` while a transaction is in flight.

## Interface
- `XLEN`, 32: address/data width; only 32 is supported.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  execute presents a request (`data_req`).
- `req_ready_o`  out  1  request is accepted when valid & ready.
- `req_wr_i`  in  1  1 = store, 0 = load (`data_wr`).
- `req_size_i`  in  2  `mem_access_size_t` (`data_byte`).
- `req_zero_extnd_i`  in  1  zero-extend the load result (`zero_extnd`).
- `req_addr_i`  in  XLEN  byte address.
- `req_wdata_i`  in  XLEN  store data (the low bits carry the value).
- `rsp_valid_o`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata_o`  out  XLEN  extended load data; 0 for stores and faults.
- `rsp_fault_o`  out  1  misaligned or illegal size; qualified by `rsp_valid_o`.
- `mem_req_o`  out  1  bus request.
- `mem_gnt_i`  in  1  bus grant.
- `mem_addr_o`  out  XLEN  word address; bits [1:0] are always 0.
- `mem_we_o`  out  1  write enable.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  XLEN  lane-replicated store data.
- `mem_rdata_i`  in  XLEN  read data, valid with `mem_rvalid_i`.
- `mem_rvalid_i`  in  1  response; returned for both reads and writes.

## Operation
- **States:** IDLE, REQ, WAIT. Every output is registered except `req_ready_o`, which is `(state==IDLE) & !reset`.
- **IDLE, on accept:** check alignment.
  - The access faults if size is HALF_WORD with `addr[0]`=1, size is WORD with `addr[1:0]`≠0, or size is DOUBLE_WORD.
  - On a fault: no bus activity; next cycle `rsp_valid_o`=1 and `rsp_fault_o`=1; state stays IDLE.
  - Otherwise: latch the bus fields and go to REQ.
- **REQ:** `mem_req_o`=1. Address, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are held stable until `mem_gnt_i`, then go to WAIT and drop `mem_req_o`.
- **WAIT:** on `mem_rvalid_i`, go to IDLE. Next cycle `rsp_valid_o`=1 with formatted data.
- **Byte enables:**
  - BYTE: `4'b0001<<addr[1:0]`.
  - HALF_WORD: `4'b0011<<addr[1:0]`.
  - WORD: `4'hF`.
- **Store data:** BYTE sends `{4{wdata[7:0]}}`; HALF_WORD sends `{2{wdata[15:0]}}`; WORD sends `wdata`.
- **Load formatting:**
  - Select the byte at `addr[1:0]`, or the halfword at `addr[1]`.
  - Sign-extend unless `zero_extnd`=1; WORD passes through.
  - Latched offset/size/extend are used, not live inputs.
- **Ignored inputs:** `mem_rvalid_i` in IDLE or REQ is a protocol violation and is ignored. `mem_gnt_i` outside REQ is ignored.

## Timing
- **Reset:** state=IDLE and all registered outputs 0; `req_ready_o`=0 while `reset`=1.
- **Reset mid-transaction:** returns to IDLE, drops `mem_req_o` next cycle, and produces no response.
- **Cycle sequence:** accept at cycle N, `mem_req_o` at N+1, gnt at G≥N+1, WAIT from G+1, rvalid at R≥G+1, `rsp_valid_o` at R+1.
- **Latency:** 3 cycles minimum from accept to response. A fault responds at N+1.
- **Back-to-back:** `req_ready_o`=1 in the cycle `rsp_valid_o` is high, so a new request can be accepted there. Maximum throughput is one access per 3 cycles.
- **Fault followed by request:** a fault response and a new accept may coincide at N+1.

## Structure
- Add `lsu_state_t` (IDLE/REQ/WAIT) to `cpu_consts`.
- Reuse the existing `mem_access_size_t`.
- Sub-module `load_data_formatter` (combinational): inputs rdata, offset, size and zero_extnd; output is the extended XLEN result. Verify it standalone.
- The FSM, alignment check and store lane replication live in `load_store_unit`.

## Test plan
- **LW:** `0x1000` with gnt at once and rvalid one cycle later, rdata `0xDEADBEEF` → `mem_be_o`=F, `mem_addr_o`=0x1000, `rsp_rdata_o`=0xDEADBEEF, `rsp_valid_o` exactly 3 cycles after accept.
- **LB / LBU:** `0x1003`, rdata `0x80112233` → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at `0x1002` gives 0xFFFF8011.
- **SB:** `0x2001`, wdata `0x000000AB` → `mem_be_o`=0010, `mem_wdata_o`=0xABABABAB, `mem_we_o`=1, `rsp_rdata_o`=0.
- **Stalled grant:** gnt held low 4 cycles, then rvalid delayed 3 cycles → bus fields stable throughout REQ, `req_ready_o`=0 until the response cycle, then a second request is accepted in the `rsp_valid_o` cycle.
- **Faults:** LW at `0x1002`, SH at `0x1001`, DOUBLE_WORD → `rsp_fault_o`=1 at N+1, `mem_req_o` never asserted.
- **Reset in WAIT:** then a stray `mem_rvalid_i` → no `rsp_valid_o`, state IDLE, next request completes normally.
